// File: rtl/four_one_mux_if.sv
// ---------------------------------------------------------------------------
// four_one_mux_if
//   Bundles the data/select inputs and the combinational/registered outputs
//   of four_one_mux. clk and rst stay plain ports on the module.
//
//   x1..x4  WIDTH  data inputs (selected by {s1,s0} = 00/01/10/11)
//   s0, s1  1      select LSB / MSB
//   op      WIDTH  combinational selected data
//   op_q    WIDTH  op registered one clk later
//   sel_q   2      registered {s1,s0}
//   sel_chg 1      registered select-change pulse (only with FOUR_ONE_MUX_SEL_CHG_EN)
//
//   master: drives inputs, observes outputs (the source/consumer side)
//   slave : the mux itself
// ---------------------------------------------------------------------------
interface four_one_mux_if #(
  parameter int WIDTH = 1
);
  logic [WIDTH-1:0] x1, x2, x3, x4;
  logic             s0, s1;
  logic [WIDTH-1:0] op;
  logic [WIDTH-1:0] op_q;
  logic [1:0]       sel_q;
`ifdef FOUR_ONE_MUX_SEL_CHG_EN
  logic             sel_chg;

  modport master (output x1, x2, x3, x4, s0, s1,
                  input  op, op_q, sel_q, sel_chg);
  modport slave  (input  x1, x2, x3, x4, s0, s1,
                  output op, op_q, sel_q, sel_chg);
`else
  modport master (output x1, x2, x3, x4, s0, s1,
                  input  op, op_q, sel_q);
  modport slave  (input  x1, x2, x3, x4, s0, s1,
                  output op, op_q, sel_q);
`endif
endinterface

// File: rtl/four_one_mux.sv
// ---------------------------------------------------------------------------
// four_one_mux
//   4:1 selector. op is the purely combinational pick of x1..x4 by {s1,s0};
//   op_q / sel_q are one-cycle registered copies for timing-critical sinks.
//
//   Ports:
//     clk  rising-edge clock
//     rst  synchronous, active-high reset (clears op_q, sel_q, sel_chg)
//     bus  four_one_mux_if.slave (x1..x4, s0, s1 in; op, op_q, sel_q out)
//
//   Optional feature, macro FOUR_ONE_MUX_SEL_CHG_EN:
//     adds bus.sel_chg, a one-cycle registered pulse when the sampled select
//     differs from sel_q. Suppressed on the first edge after reset release.
// ---------------------------------------------------------------------------

// One bit of the selector. An unknown select yields X rather than silently
// falling back to x1, so a floating select is visible in simulation.
module four_one_mux_lane (
  input  logic [3:0] d,
  input  logic [1:0] sel,
  output logic       y
);
  always_comb begin
    y = 1'bx;
    case (sel)
      2'b00:   y = d[0];
      2'b01:   y = d[1];
      2'b10:   y = d[2];
      2'b11:   y = d[3];
      default: y = 1'bx;
    endcase
  end
endmodule

module four_one_mux #(
  parameter int WIDTH = 1
) (
  input  logic           clk,
  input  logic           rst,
  four_one_mux_if.slave  bus
);
  logic [1:0]       sel;
  logic [WIDTH-1:0] op_w;

  assign sel = {bus.s1, bus.s0};

  for (genvar g = 0; g < WIDTH; g++) begin : g_lane
    four_one_mux_lane u_lane (
      .d   ({bus.x4[g], bus.x3[g], bus.x2[g], bus.x1[g]}),
      .sel (sel),
      .y   (op_w[g])
    );
  end

  assign bus.op = op_w;

  always_ff @(posedge clk) begin
    if (rst) begin
      bus.op_q  <= '0;
      bus.sel_q <= 2'b00;
    end else begin
      bus.op_q  <= op_w;
      bus.sel_q <= sel;
    end
  end

`ifdef FOUR_ONE_MUX_SEL_CHG_EN
  // rst_d remembers that the previous edge was in reset; sel_q is 00 then
  // only because of reset, so a compare against it would be a false pulse.
  logic rst_d;

  always_ff @(posedge clk) begin
    rst_d <= rst;
    if (rst)
      bus.sel_chg <= 1'b0;
    else
      bus.sel_chg <= !rst_d && (sel != bus.sel_q);
  end
`endif

endmodule

// File: tb/tb_four_one_mux.sv
module tb_four_one_mux;
  logic clk = 1'b0;
  logic rst = 1'b0;

  always #5 clk = ~clk;

  four_one_mux_if #(.WIDTH(8)) bus8 ();
  four_one_mux_if #(.WIDTH(1)) bus1 ();

  four_one_mux #(.WIDTH(8)) u_dut8 (.clk(clk), .rst(rst), .bus(bus8));
  four_one_mux #(.WIDTH(1)) u_dut1 (.clk(clk), .rst(rst), .bus(bus1));

  typedef struct {
    logic [7:0] op_q;
    logic [1:0] sel_q;
    logic       chg;
  } exp_t;

  exp_t sb[$];

  int errors = 0;
  int checks = 0;

  logic [7:0] model_op_q;
  logic [1:0] model_sel_q;
  logic       model_rst_d;
  logic       model_valid = 1'b0;

  function automatic logic [7:0] mux_model(input logic [7:0] a, b, c, d,
                                           input logic [1:0] s);
    if (s == 2'b00) return a;
    else if (s == 2'b01) return b;
    else if (s == 2'b10) return c;
    return d;
  endfunction

  // Called one unit after a rising edge. Drives both DUTs, checks the comb
  // path, pushes the expected registered state, then checks it after the edge.
  task automatic drive_cycle(input logic r, input logic [7:0] a, b, c, d,
                             input logic [1:0] s);
    exp_t e;
    logic [7:0] m;
    rst = r;
    bus8.x1 = a; bus8.x2 = b; bus8.x3 = c; bus8.x4 = d;
    bus8.s0 = s[0]; bus8.s1 = s[1];
    bus1.x1 = a[0]; bus1.x2 = b[0]; bus1.x3 = c[0]; bus1.x4 = d[0];
    bus1.s0 = s[0]; bus1.s1 = s[1];
    #1;
    m = mux_model(a, b, c, d, s);
    checks++;
    if (bus8.op !== m) begin
      errors++; $display("FAIL op8 got=%h exp=%h", bus8.op, m);
    end
    checks++;
    if (bus1.op !== m[0]) begin
      errors++; $display("FAIL op1 got=%h exp=%h", bus1.op, m[0]);
    end
    if (model_valid) begin
      checks++;
      if (bus8.op_q !== model_op_q) begin
        errors++; $display("FAIL op_q_early got=%h exp=%h", bus8.op_q, model_op_q);
      end
    end
    e.op_q  = r ? 8'h00 : m;
    e.sel_q = r ? 2'b00 : s;
    e.chg   = r ? 1'b0 : (model_rst_d ? 1'b0 : (s != model_sel_q));
    sb.push_back(e);
    model_op_q  = e.op_q;
    model_sel_q = e.sel_q;
    model_rst_d = r;
    model_valid = 1'b1;
    @(posedge clk);
    #1;
    checks++;
    if (sb.size() == 0) begin
      errors++; $display("FAIL sb_empty got=0 exp=1");
    end else begin
      e = sb.pop_front();
      if (bus8.op_q !== e.op_q) begin
        errors++; $display("FAIL op_q8 got=%h exp=%h", bus8.op_q, e.op_q);
      end
      checks++;
      if (bus8.sel_q !== e.sel_q) begin
        errors++; $display("FAIL sel_q8 got=%b exp=%b", bus8.sel_q, e.sel_q);
      end
      checks++;
      if (bus1.op_q !== e.op_q[0]) begin
        errors++; $display("FAIL op_q1 got=%b exp=%b", bus1.op_q, e.op_q[0]);
      end
      checks++;
      if (bus1.sel_q !== e.sel_q) begin
        errors++; $display("FAIL sel_q1 got=%b exp=%b", bus1.sel_q, e.sel_q);
      end
`ifdef FOUR_ONE_MUX_SEL_CHG_EN
      checks++;
      if (bus8.sel_chg !== e.chg) begin
        errors++; $display("FAIL sel_chg got=%b exp=%b", bus8.sel_chg, e.chg);
      end
`endif
    end
  endtask

  task automatic test_reset();
    drive_cycle(1'b1, 8'h5a, 8'ha5, 8'h3c, 8'hc3, 2'b11);
    drive_cycle(1'b1, 8'h5a, 8'ha5, 8'h3c, 8'hc3, 2'b01);
    drive_cycle(1'b0, 8'h00, 8'h00, 8'h00, 8'h00, 2'b00);
  endtask

  // WIDTH=1 instance, every input/select combination.
  task automatic test_comb_exhaustive();
    logic [5:0] v;
    logic [3:0] dv;
    logic       exp;
    for (int i = 0; i < 64; i++) begin
      v = 6'(i);
      bus1.x1 = v[0]; bus1.x2 = v[1]; bus1.x3 = v[2]; bus1.x4 = v[3];
      bus1.s0 = v[4]; bus1.s1 = v[5];
      #1;
      dv  = v[3:0];
      exp = dv[v[5:4]];
      checks++;
      if (bus1.op !== exp) begin
        errors++; $display("FAIL comb_exh combo=%0d got=%b exp=%b", i, bus1.op, exp);
      end
    end
  endtask

  // Toggle periods 5/10/20/40 on x4..x1, select toggles every 80/160.
  task automatic test_toggle_sweep();
    logic exp;
    int   win;
    for (int t = 0; t < 320; t += 5) begin
      bus1.x4 = 1'((t / 5) % 2);
      bus1.x3 = 1'((t / 10) % 2);
      bus1.x2 = 1'((t / 20) % 2);
      bus1.x1 = 1'((t / 40) % 2);
      bus1.s0 = 1'((t / 80) % 2);
      bus1.s1 = 1'((t / 160) % 2);
      #1;
      win = t / 80;
      case (win)
        0:       exp = 1'((t / 40) % 2);
        1:       exp = 1'((t / 20) % 2);
        2:       exp = 1'((t / 10) % 2);
        default: exp = 1'((t / 5) % 2);
      endcase
      checks++;
      if (bus1.op !== exp) begin
        errors++; $display("FAIL sweep t=%0d got=%b exp=%b", t, bus1.op, exp);
      end
      #4;
    end
    @(posedge clk);
    #1;
  endtask

  task automatic test_registered();
    drive_cycle(1'b1, 8'h00, 8'h00, 8'h00, 8'h00, 2'b00);
    drive_cycle(1'b1, 8'h00, 8'h00, 8'h00, 8'h00, 2'b00);
    drive_cycle(1'b0, 8'h00, 8'h00, 8'h01, 8'h00, 2'b10);
    drive_cycle(1'b0, 8'h00, 8'h00, 8'h01, 8'h00, 2'b10);
  endtask

  task automatic test_reset_midstream();
    drive_cycle(1'b0, 8'h01, 8'h00, 8'h00, 8'h00, 2'b00);
    drive_cycle(1'b1, 8'h01, 8'h00, 8'h00, 8'h00, 2'b00);
    drive_cycle(1'b0, 8'h01, 8'h00, 8'h00, 8'h00, 2'b00);
    drive_cycle(1'b0, 8'h01, 8'h00, 8'h00, 8'h00, 2'b00);
  endtask

  task automatic test_width8();
    drive_cycle(1'b0, 8'h11, 8'h22, 8'h33, 8'h44, 2'b11);
    drive_cycle(1'b0, 8'h11, 8'h22, 8'h33, 8'h44, 2'b10);
    drive_cycle(1'b0, 8'h11, 8'h22, 8'h33, 8'h44, 2'b01);
    drive_cycle(1'b0, 8'h11, 8'h22, 8'h33, 8'h44, 2'b00);
  endtask

  task automatic test_sel_chg();
    for (int i = 0; i < 3; i++)
      drive_cycle(1'b0, 8'h10, 8'h20, 8'h30, 8'h40, 2'b01);
    for (int i = 0; i < 3; i++)
      drive_cycle(1'b0, 8'h10, 8'h20, 8'h30, 8'h40, 2'b11);
  endtask

  task automatic test_back_to_back();
    logic       r;
    logic [1:0] s;
    for (int i = 0; i < 24; i++) begin
      r = ($urandom_range(7) == 0);
      s = 2'($urandom_range(3));
      drive_cycle(r, 8'($urandom), 8'($urandom), 8'($urandom), 8'($urandom), s);
    end
  endtask

  initial begin
    #20000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    bus8.x1 = '0; bus8.x2 = '0; bus8.x3 = '0; bus8.x4 = '0;
    bus8.s0 = 1'b0; bus8.s1 = 1'b0;
    bus1.x1 = '0; bus1.x2 = '0; bus1.x3 = '0; bus1.x4 = '0;
    bus1.s0 = 1'b0; bus1.s1 = 1'b0;
    rst = 1'b1;
    @(posedge clk);
    #1;
    test_reset();
    test_comb_exhaustive();
    @(posedge clk);
    #1;
    test_toggle_sweep();
    test_registered();
    test_reset_midstream();
    test_width8();
    test_sel_chg();
    test_back_to_back();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
